// File: rtl/sel_modo_de_jogo.sv
// sel_modo_de_jogo
// ----------------------------------------------------------------------------
// Game-mode selector. The player steps through the modes with the "next"
// button and locks the choice with the "confirm" button. The choice stays
// locked until the game core raises game_over. The 2-bit mode code {A,B}
// feeds the 7-segment mode decoder.
//
// Both raw pushbuttons pass through a 2-flop synchroniser and a counter
// debouncer. Each debouncer produces a one-cycle press event on the
// debounced 0->1 edge. A release produces no event.
//
// Event semantics: a press event is a single-cycle pulse. The FSM reacts to
// it on the following rising edge. No event is lost or queued, and no
// backpressure exists.
//
// Ports
//   clk          in   system clock, all state on the rising edge
//   reset        in   synchronous, active-high reset
//   btn_next     in   raw, asynchronous, bouncy "next mode" button
//   btn_confirm  in   raw, asynchronous, bouncy "confirm" button
//   game_over    in   synchronous level from the game core, unlocks selection
//   A            out  mode code MSB (registered)
//   B            out  mode code LSB (registered)
//   locked       out  high while the mode is confirmed (the FSM state bit)
//   start        out  one-cycle pulse on the cycle the mode becomes locked
// ----------------------------------------------------------------------------
module sel_modo_de_jogo #(
   parameter int DEBOUNCE_CYCLES = 4,   // min 1
   parameter int NUM_MODES       = 4    // 1..4
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_next,
   input  logic btn_confirm,
   input  logic game_over,
   output logic A,
   output logic B,
   output logic locked,
   output logic start
);

   localparam int              CW        = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0]   CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [1:0]      MODE_LAST = 2'(NUM_MODES - 1);

   // Button index: bit 0 = next, bit 1 = confirm.
   localparam int BTN_NEXT    = 0;
   localparam int BTN_CONFIRM = 1;

   // ------------------------------------------------------------------------
   // Input conditioning
   // ------------------------------------------------------------------------
   logic [1:0]    raw;
   logic [1:0]    sync1_q, sync1_d;
   logic [1:0]    sync2_q, sync2_d;
   logic          vld1_q, vld1_d;       // sync1 holds a post-reset sample
   logic          vld2_q, vld2_d;       // sync2 holds a post-reset sample
   logic [1:0]    deb_q, deb_d;
   logic [CW-1:0] cnt_q [2];
   logic [CW-1:0] cnt_d [2];
   logic [1:0]    armed_q, armed_d;
   logic [1:0]    press_q, press_d;

   assign raw = {btn_confirm, btn_next};

   // A button held through reset release must not produce an event.
   // Each button is "armed" only after a valid low level has been seen on
   // its synchronised input since reset. The vld flags keep the cleared
   // synchroniser contents from counting as a real low sample.
   always_comb begin
      sync1_d = raw;
      sync2_d = sync1_q;
      vld1_d  = 1'b1;
      vld2_d  = vld1_q;
      deb_d   = deb_q;
      cnt_d   = cnt_q;
      armed_d = armed_q;
      press_d = '0;
      for (int i = 0; i < 2; i++) begin
         if (sync2_q[i] == deb_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CNT_LAST) begin
            // This cycle is the DEBOUNCE_CYCLES-th consecutive difference.
            deb_d[i] = sync2_q[i];
            cnt_d[i] = '0;
         end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
         end
         armed_d[i] = armed_q[i] | (vld2_q & ~sync2_q[i]);
         press_d[i] = deb_d[i] & ~deb_q[i] & armed_q[i];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
         vld1_q  <= 1'b0;
         vld2_q  <= 1'b0;
         deb_q   <= '0;
         cnt_q   <= '{default: '0};
         armed_q <= '0;
         press_q <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         vld1_q  <= vld1_d;
         vld2_q  <= vld2_d;
         deb_q   <= deb_d;
         cnt_q   <= cnt_d;
         armed_q <= armed_d;
         press_q <= press_d;
      end
   end

   logic next_ev;
   logic confirm_ev;

   assign next_ev    = press_q[BTN_NEXT];
   assign confirm_ev = press_q[BTN_CONFIRM];

   // ------------------------------------------------------------------------
   // Mode FSM
   // ------------------------------------------------------------------------
   typedef enum logic {
      ST_SELECT = 1'b0,
      ST_LOCKED = 1'b1
   } state_t;

   state_t     state_q, state_d;
   logic [1:0] mode_q, mode_d;
   logic       start_q, start_d;

   // State register, together with the registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_SELECT;
         mode_q  <= 2'b00;
         start_q <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         start_q <= start_d;
      end
   end

   // Next state. In LOCKED, button events are ignored. In SELECT, game_over
   // is ignored.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_SELECT: if (confirm_ev) state_d = ST_LOCKED;
         ST_LOCKED: if (game_over)  state_d = ST_SELECT;
         default:   state_d = ST_SELECT;
      endcase
   end

   // Next values of the registered outputs. Confirm takes priority over
   // next, so a simultaneous pair locks the current mode unchanged.
   always_comb begin
      mode_d  = mode_q;
      start_d = 1'b0;
      if (state_q == ST_SELECT) begin
         if (confirm_ev) begin
            start_d = 1'b1;
         end else if (next_ev) begin
            mode_d = (mode_q == MODE_LAST) ? 2'b00 : mode_q + 2'b01;
         end
      end
   end

   assign A      = mode_q[1];
   assign B      = mode_q[0];
   assign locked = (state_q == ST_LOCKED);
   assign start  = start_q;

endmodule
